// File: rtl/button_conditioner_if.sv
// Push-button conditioning bus: raw pin inputs in, clean levels, edge pulses
// and the stretched CPU reset out.
interface button_conditioner_if #(
   parameter int NUM_BUTTONS = 5
);
   logic [NUM_BUTTONS-1:0] buttons_raw;
   logic [NUM_BUTTONS-1:0] buttons_level;
   logic [NUM_BUTTONS-1:0] buttons_pressed;
   logic [NUM_BUTTONS-1:0] buttons_released;
   logic                   sys_reset;

   modport master (
      output buttons_raw,
      input  buttons_level,
      input  buttons_pressed,
      input  buttons_released,
      input  sys_reset
   );

   modport slave (
      input  buttons_raw,
      output buttons_level,
      output buttons_pressed,
      output buttons_released,
      output sys_reset
   );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises and debounces the board push-buttons, emits press/release
// pulses, and stretches a CPU reset that one button can re-trigger.
module button_conditioner #(
   parameter int NUM_BUTTONS     = 5,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int RESET_BUTTON    = 0,
   parameter int RESET_HOLD      = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   button_conditioner_if.slave  bus
);

   localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
   localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

   logic [NUM_BUTTONS-1:0]            sync1_q, sync1_d;
   logic [NUM_BUTTONS-1:0]            sync2_q, sync2_d;
   logic [NUM_BUTTONS-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [NUM_BUTTONS-1:0]            level_q, level_d;
   logic [NUM_BUTTONS-1:0]            pressed_q, pressed_d;
   logic [NUM_BUTTONS-1:0]            released_q, released_d;
   logic [HOLD_W-1:0]                 hold_cnt_q, hold_cnt_d;
   logic                              sys_reset_q, sys_reset_d;

   always_comb begin
      sync1_d    = bus.buttons_raw;
      sync2_d    = sync1_q;
      cnt_d      = cnt_q;
      level_d    = level_q;
      pressed_d  = '0;
      released_d = '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         // A level flips only after DEBOUNCE_CYCLES back-to-back mismatches;
         // any agreeing edge drops the partial count.
         if (sync2_q[i] != level_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               level_d[i]    = ~level_q[i];
               cnt_d[i]      = '0;
               pressed_d[i]  = ~level_q[i];
               released_d[i] = level_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end else begin
            cnt_d[i] = '0;
         end
      end
   end

   always_comb begin
      hold_cnt_d  = hold_cnt_q;
      sys_reset_d = sys_reset_q;
      // A fresh press restarts the hold window rather than extending it.
      if (pressed_q[RESET_BUTTON]) begin
         sys_reset_d = 1'b1;
         hold_cnt_d  = '0;
      end else if (sys_reset_q) begin
         if (hold_cnt_q == HOLD_LAST) begin
            sys_reset_d = 1'b0;
            hold_cnt_d  = '0;
         end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         cnt_q       <= '0;
         level_q     <= '0;
         pressed_q   <= '0;
         released_q  <= '0;
         hold_cnt_q  <= '0;
         sys_reset_q <= 1'b1;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         cnt_q       <= cnt_d;
         level_q     <= level_d;
         pressed_q   <= pressed_d;
         released_q  <= released_d;
         hold_cnt_q  <= hold_cnt_d;
         sys_reset_q <= sys_reset_d;
      end
   end

   assign bus.buttons_level    = level_q;
   assign bus.buttons_pressed  = pressed_q;
   assign bus.buttons_released = released_q;
   assign bus.sys_reset        = sys_reset_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, RESET_HOLD=8.
module tb_button_conditioner;

   localparam int NB = 5;
   localparam int DC = 4;
   localparam int RH = 8;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   button_conditioner_if #(.NUM_BUTTONS(NB)) bus ();

   button_conditioner #(
      .NUM_BUTTONS(NB),
      .DEBOUNCE_CYCLES(DC),
      .RESET_BUTTON(0),
      .RESET_HOLD(RH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [NB-1:0] lvl,
                             input logic [NB-1:0] prs, input logic [NB-1:0] rel,
                             input logic sr);
      check({tag, ".level"},    32'(bus.buttons_level),    32'(lvl));
      check({tag, ".pressed"},  32'(bus.buttons_pressed),  32'(prs));
      check({tag, ".released"}, 32'(bus.buttons_released), 32'(rel));
      check({tag, ".sys_reset"}, 32'(bus.sys_reset),       32'(sr));
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [5:0] gl;
      gl = 6'b110111;
      bus.buttons_raw = '0;

      // Reset: asserted before any clock edge, so clearing is asynchronous.
      #1 reset = 1'b1;
      #1 check_outs("rst_init", 5'b00000, 5'b00000, 5'b00000, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         tick();
         check_outs($sformatf("rst_hold[%0d]", j), 5'b00000, 5'b00000, 5'b00000, j < 8);
      end

      // Single press on button 2, held.
      bus.buttons_raw[2] = 1'b1;
      for (int k = 0; k <= 12; k++) begin
         tick();
         check_outs($sformatf("press2[%0d]", k), (k >= 5) ? 5'b00100 : 5'b00000,
                    (k == 5) ? 5'b00100 : 5'b00000, 5'b00000, 1'b0);
      end

      // Glitches on button 1 shorter than the debounce window.
      for (int k = 0; k < 16; k++) begin
         bus.buttons_raw[1] = (k < 6) ? gl[k] : 1'b0;
         tick();
         check_outs($sformatf("glitch1[%0d]", k), 5'b00100, 5'b00000, 5'b00000, 1'b0);
      end

      // Buttons 3 and 4 together.
      bus.buttons_raw[4:3] = 2'b11;
      for (int k = 0; k < 20; k++) begin
         tick();
         check_outs($sformatf("press34[%0d]", k), (k >= 5) ? 5'b11100 : 5'b00100,
                    (k == 5) ? 5'b11000 : 5'b00000, 5'b00000, 1'b0);
      end
      bus.buttons_raw[4:3] = 2'b00;
      for (int k = 0; k < 10; k++) begin
         tick();
         check_outs($sformatf("rel34[%0d]", k), (k >= 5) ? 5'b00100 : 5'b11100,
                    5'b00000, (k == 5) ? 5'b11000 : 5'b00000, 1'b0);
      end

      // Reset button: press, release, press again inside the hold window.
      bus.buttons_raw[0] = 1'b1;
      for (int k = 0; k <= 24; k++) begin
         logic l0;
         tick();
         l0 = ((k >= 5) && (k < 9)) || (k >= 13);
         check_outs($sformatf("rstbtn[%0d]", k), {4'b0010, l0},
                    {4'b0000, (k == 5) || (k == 13)}, {4'b0000, k == 9},
                    (k >= 6) && (k < 22));
         if (k == 3) bus.buttons_raw[0] = 1'b0;
         if (k == 7) bus.buttons_raw[0] = 1'b1;
      end

      bus.buttons_raw[2] = 1'b0;
      repeat (10) tick();
      check_outs("rel2", 5'b00001, 5'b00000, 5'b00000, 1'b0);

      // Asynchronous reset in the middle of a debounce count.
      bus.buttons_raw[2] = 1'b1;
      repeat (3) tick();
      @(posedge clk);
      #2 reset = 1'b1;
      #1 check_outs("async_rst", 5'b00000, 5'b00000, 5'b00000, 1'b1);
      bus.buttons_raw[0] = 1'b0;
      @(negedge clk);
      tick();
      reset = 1'b0;
      for (int j = 1; j <= 10; j++) begin
         tick();
         check_outs($sformatf("post_rst[%0d]", j), (j >= 6) ? 5'b00100 : 5'b00000,
                    (j == 6) ? 5'b00100 : 5'b00000, 5'b00000, j < 8);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
